axi_sram_slave: RTL and testbench

- AXI3-style responder fronting an internal word-addressed register-array SRAM.
- Serves as the memory model/target for the cache-side AXI initiator: accepts single and INCR bursts up to 16 beats on independent read and write channels.
- No outstanding transactions per channel. Read and write channels operate concurrently.

---
 rtl/axi_sram_slave_if.sv | 68 ++++++
 rtl/axi_sram_slave.sv | 170 +++++++++++++++++
 tb/tb_axi_sram_slave.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_sram_slave_if.sv
// AXI3-style bus bundle between a cache-side initiator and the SRAM responder.
// The master modport drives requests and write data; the slave modport drives the responses.
interface axi_sram_slave_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4
) ();
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [3:0]              AWLEN;
  logic [2:0]              AWSIZE;
  logic [1:0]              AWBURST;
  logic [ID_WIDTH-1:0]     AWID;
  logic                    AWVALID;
  logic                    AWREADY;

  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WLAST;
  logic [ID_WIDTH-1:0]     WID;
  logic                    WVALID;
  logic                    WREADY;

  logic [1:0]              BRESP;
  logic [ID_WIDTH-1:0]     BID;
  logic                    BVALID;
  logic                    BREADY;

  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [3:0]              ARLEN;
  logic [2:0]              ARSIZE;
  logic [1:0]              ARBURST;
  logic [ID_WIDTH-1:0]     ARID;
  logic                    ARVALID;
  logic                    ARREADY;

  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RLAST;
  logic [ID_WIDTH-1:0]     RID;
  logic                    RVALID;
  logic                    RREADY;

  modport slave (
    input  AWADDR, AWLEN, AWSIZE, AWBURST, AWID, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WID, WVALID,
    output WREADY,
    output BRESP, BID, BVALID,
    input  BREADY,
    input  ARADDR, ARLEN, ARSIZE, ARBURST, ARID, ARVALID,
    output ARREADY,
    output RDATA, RRESP, RLAST, RID, RVALID,
    input  RREADY
  );

  modport master (
    output AWADDR, AWLEN, AWSIZE, AWBURST, AWID, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WID, WVALID,
    input  WREADY,
    input  BRESP, BID, BVALID,
    output BREADY,
    output ARADDR, ARLEN, ARSIZE, ARBURST, ARID, ARVALID,
    input  ARREADY,
    input  RDATA, RRESP, RLAST, RID, RVALID,
    output RREADY
  );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI3-style responder in front of a word-addressed register-array SRAM.
// Independent read and write FSMs, one burst in flight per channel, INCR/FIXED up to 16 beats.
module axi_sram_slave #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned MEM_AW     = 10
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  axi_sram_slave_if.slave   s_axi
);

  localparam int unsigned Depth = 1 << MEM_AW;
  localparam int unsigned NumBytes = DATA_WIDTH / 8;

  typedef enum logic [1:0] {WIdle, WData, WResp} wstate_e;
  typedef enum logic {RIdle, RData} rstate_e;

  logic [DATA_WIDTH-1:0] r_mem [Depth];

  // Write channel
  wstate_e               r_wstate, w_wstate_nxt;
  logic [MEM_AW-1:0]     r_widx;
  logic [3:0]            r_awlen;
  logic                  r_wfixed;
  logic                  r_wsize_bad;
  logic [4:0]            r_wbeats;
  logic [ID_WIDTH-1:0]   r_bid;
  logic [1:0]            r_bresp;
  logic                  w_aw_hs, w_w_hs;
  logic [4:0]            w_wbeat_num;
  logic                  w_wlen_ok;

  assign w_aw_hs = s_axi.AWVALID && s_axi.AWREADY;
  assign w_w_hs  = s_axi.WVALID && s_axi.WREADY;
  // Beat number of the current beat, saturating so long bursts still flag SLVERR
  assign w_wbeat_num = (r_wbeats == 5'd31) ? 5'd31 : r_wbeats + 5'd1;
  assign w_wlen_ok   = (w_wbeat_num == ({1'b0, r_awlen} + 5'd1));

  assign s_axi.AWREADY = (r_wstate == WIdle);
  assign s_axi.WREADY  = (r_wstate == WData);
  assign s_axi.BVALID  = (r_wstate == WResp);
  assign s_axi.BID     = r_bid;
  assign s_axi.BRESP   = r_bresp;

  always_comb begin
    w_wstate_nxt = r_wstate;
    unique case (r_wstate)
      WIdle:   if (w_aw_hs) w_wstate_nxt = WData;
      WData:   if (w_w_hs && s_axi.WLAST) w_wstate_nxt = WResp;
      WResp:   if (s_axi.BREADY) w_wstate_nxt = WIdle;
      default: w_wstate_nxt = WIdle;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) r_wstate <= WIdle;
    else          r_wstate <= w_wstate_nxt;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_widx      <= '0;
      r_awlen     <= '0;
      r_wfixed    <= 1'b0;
      r_wsize_bad <= 1'b0;
      r_wbeats    <= '0;
      r_bid       <= '0;
      r_bresp     <= '0;
    end else begin
      if (w_aw_hs) begin
        r_widx      <= s_axi.AWADDR[MEM_AW+1:2];
        r_awlen     <= s_axi.AWLEN;
        r_wfixed    <= (s_axi.AWBURST == 2'b00);
        r_wsize_bad <= (s_axi.AWSIZE != 3'b010);
        r_bid       <= s_axi.AWID;
        r_wbeats    <= '0;
      end
      if (w_w_hs) begin
        r_wbeats <= w_wbeat_num;
        if (!r_wfixed) r_widx <= r_widx + 1'b1;
        if (s_axi.WLAST) r_bresp <= (!w_wlen_ok || r_wsize_bad) ? 2'b10 : 2'b00;
      end
    end
  end

  // Storage is deliberately left out of reset
  always_ff @(posedge ACLK) begin
    if (ARESETn && w_w_hs) begin
      for (int b = 0; b < NumBytes; b++) begin
        if (s_axi.WSTRB[b]) r_mem[r_widx][8*b +: 8] <= s_axi.WDATA[8*b +: 8];
      end
    end
  end

  // Read channel
  rstate_e               r_rstate, w_rstate_nxt;
  logic [MEM_AW-1:0]     r_ridx;
  logic [3:0]            r_arlen;
  logic [3:0]            r_rbeat;
  logic                  r_rfixed;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rlast;
  logic [ID_WIDTH-1:0]   r_rid;
  logic                  w_ar_hs, w_r_hs;
  logic [MEM_AW-1:0]     w_ar_idx, w_ridx_nxt;

  assign w_ar_hs    = s_axi.ARVALID && s_axi.ARREADY;
  assign w_r_hs     = s_axi.RVALID && s_axi.RREADY;
  assign w_ar_idx   = s_axi.ARADDR[MEM_AW+1:2];
  assign w_ridx_nxt = r_rfixed ? r_ridx : r_ridx + 1'b1;

  assign s_axi.ARREADY = (r_rstate == RIdle);
  assign s_axi.RVALID  = (r_rstate == RData);
  assign s_axi.RDATA   = r_rdata;
  assign s_axi.RLAST   = r_rlast;
  assign s_axi.RID     = r_rid;
  assign s_axi.RRESP   = 2'b00;

  always_comb begin
    w_rstate_nxt = r_rstate;
    unique case (r_rstate)
      RIdle:   if (w_ar_hs) w_rstate_nxt = RData;
      RData:   if (w_r_hs && r_rlast) w_rstate_nxt = RIdle;
      default: w_rstate_nxt = RIdle;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) r_rstate <= RIdle;
    else          r_rstate <= w_rstate_nxt;
  end

  // Loads sample the array before same-edge writes land, so reads see old data
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_ridx   <= '0;
      r_arlen  <= '0;
      r_rbeat  <= '0;
      r_rfixed <= 1'b0;
      r_rdata  <= '0;
      r_rlast  <= 1'b0;
      r_rid    <= '0;
    end else if (w_ar_hs) begin
      r_ridx   <= w_ar_idx;
      r_arlen  <= s_axi.ARLEN;
      r_rbeat  <= '0;
      r_rfixed <= (s_axi.ARBURST == 2'b00);
      r_rdata  <= r_mem[w_ar_idx];
      r_rlast  <= (s_axi.ARLEN == 4'd0);
      r_rid    <= s_axi.ARID;
    end else if (w_r_hs) begin
      if (r_rlast) begin
        r_rlast <= 1'b0;
      end else begin
        r_ridx  <= w_ridx_nxt;
        r_rbeat <= r_rbeat + 4'd1;
        r_rdata <= r_mem[w_ridx_nxt];
        r_rlast <= ((r_rbeat + 4'd1) == r_arlen);
      end
    end
  end

  logic w_unused;
  assign w_unused = ^{s_axi.AWADDR[ADDR_WIDTH-1:MEM_AW+2], s_axi.AWADDR[1:0],
                      s_axi.ARADDR[ADDR_WIDTH-1:MEM_AW+2], s_axi.ARADDR[1:0],
                      s_axi.ARSIZE, s_axi.WID};

endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomised bench for axi_sram_slave: a bus-level memory model predicts every read beat
// and write response; scenario tasks cover bursts, strobes, SLVERR, concurrency and reset.
module tb_axi_sram_slave;

  logic ACLK;
  logic ARESETn;

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  axi_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) bus ();

  axi_sram_slave #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(4), .MEM_AW(10)
  ) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .s_axi   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a word array updated on observed W handshakes; each read beat's
  // expected value is the array content at the edge the beat is fetched.
  logic [31:0] m_mem [1024];
  logic [9:0]  m_widx, m_ridx;
  logic        m_wfixed, m_rfixed, m_ract;
  logic [3:0]  m_rlen, m_rbeat;
  logic [31:0] exp_rq [$];

  always @(posedge ACLK) begin
    if (!ARESETn) begin
      m_ract = 1'b0;
      exp_rq.delete();
    end else begin
      if (bus.ARVALID && bus.ARREADY) begin
        m_ridx = bus.ARADDR[11:2]; m_rfixed = (bus.ARBURST == 2'b00);
        m_rlen = bus.ARLEN; m_rbeat = 4'd0; m_ract = 1'b1;
        exp_rq.push_back(m_mem[m_ridx]);
      end else if (m_ract && bus.RVALID && bus.RREADY) begin
        if (m_rbeat == m_rlen) m_ract = 1'b0;
        else begin
          m_rbeat = m_rbeat + 4'd1;
          if (!m_rfixed) m_ridx = m_ridx + 10'd1;
          exp_rq.push_back(m_mem[m_ridx]);
        end
      end
      if (bus.AWVALID && bus.AWREADY) begin
        m_widx = bus.AWADDR[11:2]; m_wfixed = (bus.AWBURST == 2'b00);
      end
      if (bus.WVALID && bus.WREADY) begin
        for (int b = 0; b < 4; b++) if (bus.WSTRB[b]) m_mem[m_widx][8*b +: 8] = bus.WDATA[8*b +: 8];
        if (!m_wfixed) m_widx = m_widx + 10'd1;
      end
    end
  end

  logic [31:0] wd_buf [32];
  logic [3:0]  ws_buf [32];
  logic [1:0]  wr_bresp;
  logic [3:0]  wr_bid;
  int          wr_err;
  logic [31:0] rd_buf [32];
  logic        rl_buf [32];
  logic [3:0]  rid_buf [32];
  logic [1:0]  rd_resp_or;
  int          rd_nb;
  int          rd_err;

  task automatic do_write(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                          input logic [3:0] id, input logic [2:0] size, input int nbeats,
                          input int bdly);
    int n;
    wr_err = 0;
    @(negedge ACLK);
    bus.AWADDR = addr; bus.AWLEN = len; bus.AWBURST = burst; bus.AWID = id; bus.AWSIZE = size;
    bus.AWVALID = 1'b1;
    n = 0;
    while (!bus.AWREADY && n < 200) begin @(negedge ACLK); n++; end
    if (n >= 200) wr_err++;
    @(negedge ACLK);
    bus.AWVALID = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      bus.WDATA = wd_buf[i]; bus.WSTRB = ws_buf[i]; bus.WLAST = (i == nbeats - 1);
      bus.WID = id; bus.WVALID = 1'b1;
      n = 0;
      while (!bus.WREADY && n < 200) begin @(negedge ACLK); n++; end
      if (n >= 200) wr_err++;
      @(negedge ACLK);
    end
    bus.WVALID = 1'b0; bus.WLAST = 1'b0; bus.BREADY = 1'b0;
    n = 0;
    while (!bus.BVALID && n < 200) begin @(negedge ACLK); n++; end
    if (n >= 200) wr_err++;
    for (int i = 0; i < bdly; i++) begin
      @(negedge ACLK);
      if (!bus.BVALID) wr_err++;
    end
    wr_bresp = bus.BRESP; wr_bid = bus.BID;
    bus.BREADY = 1'b1;
    @(negedge ACLK);
    bus.BREADY = 1'b0;
    if (bus.BVALID || !bus.AWREADY) wr_err++;
  endtask

  // mode: 0 always ready, 1 toggle each cycle, 2 stall 3 cycles first, 3 random
  task automatic do_read(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                         input logic [3:0] id, input logic [2:0] size, input int mode);
    int n, cyc;
    logic rr, stalled, done;
    logic [31:0] sd;
    logic sl;
    rd_err = 0; rd_nb = 0; rd_resp_or = 2'b00;
    @(negedge ACLK);
    bus.ARADDR = addr; bus.ARLEN = len; bus.ARBURST = burst; bus.ARID = id; bus.ARSIZE = size;
    bus.ARVALID = 1'b1;
    n = 0;
    while (!bus.ARREADY && n < 200) begin @(negedge ACLK); n++; end
    if (n >= 200) rd_err++;
    @(negedge ACLK);
    bus.ARVALID = 1'b0;
    cyc = 0; stalled = 1'b0; done = 1'b0; sd = '0; sl = 1'b0;
    while (!done && cyc < 300) begin
      case (mode)
        0:       rr = 1'b1;
        1:       rr = ((cyc % 2) == 1);
        2:       rr = (cyc >= 3);
        default: rr = ($urandom_range(0, 1) == 1);
      endcase
      bus.RREADY = rr;
      if (stalled && (bus.RDATA !== sd || bus.RLAST !== sl || !bus.RVALID)) rd_err++;
      stalled = 1'b0;
      if (bus.RVALID && rr) begin
        rd_buf[rd_nb] = bus.RDATA; rl_buf[rd_nb] = bus.RLAST; rid_buf[rd_nb] = bus.RID;
        rd_resp_or = rd_resp_or | bus.RRESP;
        rd_nb++;
        if (bus.RLAST || rd_nb >= 32) done = 1'b1;
      end else if (bus.RVALID) begin
        stalled = 1'b1; sd = bus.RDATA; sl = bus.RLAST;
      end
      @(negedge ACLK);
      cyc++;
    end
    bus.RREADY = 1'b0;
    if (!done) rd_err++;
    if (!bus.ARREADY || bus.RVALID) rd_err++;
  endtask

  task automatic test_reset();
    ARESETn = 1'b0;
    repeat (3) @(negedge ACLK);
    n_tests++;
    if ({bus.BVALID, bus.RVALID, bus.RLAST, bus.WREADY} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_valids: got %b, want 0000", {bus.BVALID, bus.RVALID, bus.RLAST, bus.WREADY});
    end
    n_tests++;
    if ({bus.BRESP, bus.BID, bus.RDATA, bus.RID, bus.RRESP} !== 44'd0) begin
      n_fail++;
      $display("FAIL reset_regs: got %h, want 0", {bus.BRESP, bus.BID, bus.RDATA, bus.RID, bus.RRESP});
    end
    ARESETn = 1'b1;
    @(negedge ACLK);
    n_tests++;
    if ({bus.AWREADY, bus.ARREADY} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_ready: got %b, want 11", {bus.AWREADY, bus.ARREADY});
    end
  endtask

  task automatic test_fill();
    for (int k = 0; k < 64; k++) begin
      for (int i = 0; i < 16; i++) begin wd_buf[i] = $urandom; ws_buf[i] = 4'hF; end
      do_write(32'(k * 64), 4'd15, 2'b01, 4'(k), 3'b010, 16, 0);
      n_tests++;
      if (wr_err != 0 || wr_bresp !== 2'b00 || wr_bid !== 4'(k)) begin
        n_fail++;
        $display("FAIL fill_%0d: err %0d bresp %b bid %0d, want 0 00 %0d", k, wr_err, wr_bresp, wr_bid, k[3:0]);
      end
    end
  endtask

  task automatic test_single();
    wd_buf[0] = 32'hDEADBEEF; ws_buf[0] = 4'hF;
    do_write(32'h10, 4'd0, 2'b01, 4'd3, 3'b010, 1, 0);
    n_tests++;
    if (wr_err != 0 || wr_bid !== 4'd3 || wr_bresp !== 2'b00) begin
      n_fail++;
      $display("FAIL single_b: err %0d bid %0d bresp %b, want 0 3 00", wr_err, wr_bid, wr_bresp);
    end
    do_read(32'h10, 4'd0, 2'b01, 4'd5, 3'b010, 0);
    n_tests++;
    if (rd_err != 0 || rd_nb != 1 || rd_buf[0] !== 32'hDEADBEEF || rl_buf[0] !== 1'b1 ||
        rid_buf[0] !== 4'd5) begin
      n_fail++;
      $display("FAIL single_r: err %0d nb %0d data %h last %b id %0d, want 0 1 deadbeef 1 5",
               rd_err, rd_nb, rd_buf[0], rl_buf[0], rid_buf[0]);
    end
    exp_rq.delete();
  endtask

  task automatic test_burst4();
    for (int i = 0; i < 4; i++) begin wd_buf[i] = 32'(i + 1); ws_buf[i] = 4'hF; end
    do_write(32'h100, 4'd3, 2'b01, 4'd7, 3'b010, 4, 5);
    n_tests++;
    if (wr_err != 0 || wr_bresp !== 2'b00 || wr_bid !== 4'd7) begin
      n_fail++;
      $display("FAIL burst4_b: err %0d bresp %b bid %0d, want 0 00 7", wr_err, wr_bresp, wr_bid);
    end
    do_read(32'h100, 4'd3, 2'b01, 4'd2, 3'b010, 1);
    n_tests++;
    if (rd_err != 0 || rd_nb != 4) begin
      n_fail++;
      $display("FAIL burst4_r: err %0d beats %0d, want 0 4", rd_err, rd_nb);
    end
    for (int i = 0; i < rd_nb && i < 4; i++) begin
      n_tests++;
      if (rd_buf[i] !== 32'(i + 1) || rl_buf[i] !== (i == 3)) begin
        n_fail++;
        $display("FAIL burst4_beat%0d: data %h last %b, want %h %b", i, rd_buf[i], rl_buf[i], i + 1, i == 3);
      end
    end
    exp_rq.delete();
  endtask

  task automatic test_strobe();
    wd_buf[0] = 32'h11223344; ws_buf[0] = 4'hF;
    do_write(32'h20, 4'd0, 2'b01, 4'd1, 3'b010, 1, 0);
    wd_buf[0] = 32'hAABBCCDD; ws_buf[0] = 4'b0101;
    do_write(32'h20, 4'd0, 2'b01, 4'd1, 3'b010, 1, 0);
    do_read(32'h20, 4'd0, 2'b01, 4'd1, 3'b010, 0);
    n_tests++;
    if (rd_err != 0 || rd_buf[0] !== 32'h11BB33DD) begin
      n_fail++;
      $display("FAIL strobe: err %0d data %h, want 0 11bb33dd", rd_err, rd_buf[0]);
    end
    exp_rq.delete();
  endtask

  task automatic test_slverr();
    // WLAST early: AWLEN=3 but only 2 beats
    wd_buf[0] = 32'hA1; wd_buf[1] = 32'hA2; ws_buf[0] = 4'hF; ws_buf[1] = 4'hF;
    do_write(32'h40, 4'd3, 2'b01, 4'd9, 3'b010, 2, 0);
    n_tests++;
    if (wr_err != 0 || wr_bresp !== 2'b10 || wr_bid !== 4'd9) begin
      n_fail++;
      $display("FAIL early_last: err %0d bresp %b bid %0d, want 0 10 9", wr_err, wr_bresp, wr_bid);
    end
    do_read(32'h40, 4'd1, 2'b01, 4'd0, 3'b010, 0);
    n_tests++;
    if (rd_buf[0] !== 32'hA1 || rd_buf[1] !== 32'hA2 || rd_nb != 2) begin
      n_fail++;
      $display("FAIL early_data: got %h %h, want a1 a2", rd_buf[0], rd_buf[1]);
    end
    exp_rq.delete();
    // Extra beats past AWLEN are still written
    for (int i = 0; i < 3; i++) begin wd_buf[i] = 32'hB0 + 32'(i); ws_buf[i] = 4'hF; end
    do_write(32'h60, 4'd1, 2'b01, 4'd4, 3'b010, 3, 0);
    n_tests++;
    if (wr_bresp !== 2'b10) begin
      n_fail++;
      $display("FAIL extra_beats: bresp %b, want 10", wr_bresp);
    end
    do_read(32'h60, 4'd2, 2'b01, 4'd0, 3'b010, 0);
    n_tests++;
    if (rd_buf[2] !== 32'hB2 || rd_nb != 3) begin
      n_fail++;
      $display("FAIL extra_data: beat2 %h, want b2", rd_buf[2]);
    end
    exp_rq.delete();
    // Illegal AWSIZE flags SLVERR; illegal ARSIZE still returns OKAY
    wd_buf[0] = 32'hC0FFEE00; ws_buf[0] = 4'hF;
    do_write(32'h70, 4'd0, 2'b01, 4'd2, 3'b011, 1, 1);
    n_tests++;
    if (wr_bresp !== 2'b10) begin
      n_fail++;
      $display("FAIL bad_awsize: bresp %b, want 10", wr_bresp);
    end
    do_read(32'h70, 4'd0, 2'b01, 4'd6, 3'b001, 0);
    n_tests++;
    if (rd_resp_or !== 2'b00 || rd_buf[0] !== 32'hC0FFEE00) begin
      n_fail++;
      $display("FAIL bad_arsize: rresp %b data %h, want 00 c0ffee00", rd_resp_or, rd_buf[0]);
    end
    exp_rq.delete();
  endtask

  task automatic test_fixed();
    logic [31:0] nb_word;
    nb_word = m_mem[33];
    for (int i = 0; i < 4; i++) begin wd_buf[i] = 32'hF1F0 + 32'(i); ws_buf[i] = 4'hF; end
    do_write(32'h80, 4'd3, 2'b00, 4'd8, 3'b010, 4, 0);
    do_read(32'h80, 4'd3, 2'b00, 4'd8, 3'b010, 3);
    n_tests++;
    if (rd_nb != 4 || rd_buf[0] !== 32'hF1F3 || rd_buf[3] !== 32'hF1F3) begin
      n_fail++;
      $display("FAIL fixed_data: nb %0d beats %h %h, want 4 f1f3 f1f3", rd_nb, rd_buf[0], rd_buf[3]);
    end
    exp_rq.delete();
    do_read(32'h84, 4'd0, 2'b01, 4'd8, 3'b010, 0);
    n_tests++;
    if (rd_buf[0] !== nb_word) begin
      n_fail++;
      $display("FAIL fixed_neighbour: got %h, want %h", rd_buf[0], nb_word);
    end
    exp_rq.delete();
  endtask

  task automatic test_concurrent();
    logic [31:0] old0, new15;
    int wr_e;
    old0 = m_mem[10'h80];
    for (int i = 0; i < 16; i++) begin wd_buf[i] = $urandom; ws_buf[i] = 4'hF; end
    new15 = wd_buf[15];
    exp_rq.delete();
    fork
      do_write(32'h200, 4'd15, 2'b01, 4'd11, 3'b010, 16, 0);
      do_read(32'h200, 4'd15, 2'b01, 4'd12, 3'b010, 2);
    join
    wr_e = wr_err;
    n_tests++;
    if (wr_e != 0 || rd_err != 0 || rd_nb != 16 || wr_bresp !== 2'b00) begin
      n_fail++;
      $display("FAIL conc_done: werr %0d rerr %0d beats %0d bresp %b, want 0 0 16 00",
               wr_e, rd_err, rd_nb, wr_bresp);
    end
    n_tests++;
    if (rd_buf[0] !== old0 || rd_buf[15] !== new15) begin
      n_fail++;
      $display("FAIL conc_order: first %h last %h, want %h %h", rd_buf[0], rd_buf[15], old0, new15);
    end
    for (int i = 0; i < rd_nb; i++) begin
      logic [31:0] e;
      e = (exp_rq.size() > 0) ? exp_rq.pop_front() : 32'hX;
      n_tests++;
      if (rd_buf[i] !== e) begin
        n_fail++;
        $display("FAIL conc_beat%0d: got %h, want %h", i, rd_buf[i], e);
      end
    end
    exp_rq.delete();
  endtask

  task automatic test_reset_mid();
    int n;
    for (int i = 0; i < 4; i++) begin wd_buf[i] = 32'h3000 + 32'(i); ws_buf[i] = 4'hF; end
    do_write(32'h300, 4'd3, 2'b01, 4'd1, 3'b010, 4, 0);
    @(negedge ACLK);
    bus.ARADDR = 32'h300; bus.ARLEN = 4'd3; bus.ARBURST = 2'b01; bus.ARID = 4'd3;
    bus.ARSIZE = 3'b010; bus.ARVALID = 1'b1;
    n = 0;
    while (!bus.ARREADY && n < 200) begin @(negedge ACLK); n++; end
    @(negedge ACLK);
    bus.ARVALID = 1'b0; bus.RREADY = 1'b1;
    n = 0;
    while (!bus.RVALID && n < 200) begin @(negedge ACLK); n++; end
    @(negedge ACLK);
    bus.RREADY = 1'b0; ARESETn = 1'b0;
    @(negedge ACLK);
    n_tests++;
    if (bus.RVALID !== 1'b0 || bus.RLAST !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_rvalid: rvalid %b rlast %b, want 0 0", bus.RVALID, bus.RLAST);
    end
    ARESETn = 1'b1;
    @(negedge ACLK);
    n_tests++;
    if (bus.ARREADY !== 1'b1 || bus.AWREADY !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_ready: arready %b awready %b, want 1 1", bus.ARREADY, bus.AWREADY);
    end
    exp_rq.delete();
    do_read(32'h300, 4'd3, 2'b01, 4'd3, 3'b010, 0);
    n_tests++;
    if (rd_err != 0 || rd_nb != 4 || rd_buf[0] !== 32'h3000 || rd_buf[3] !== 32'h3003) begin
      n_fail++;
      $display("FAIL midreset_fresh: err %0d nb %0d %h %h, want 0 4 3000 3003",
               rd_err, rd_nb, rd_buf[0], rd_buf[3]);
    end
    exp_rq.delete();
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      logic [31:0] addr;
      logic [3:0] len, id;
      logic [1:0] burst, exp_b;
      logic [2:0] size;
      int nbeats;
      addr = $urandom; len = 4'($urandom_range(0, 15)); burst = 2'($urandom_range(0, 3));
      id = 4'($urandom); size = ($urandom_range(0, 7) == 0) ? 3'b001 : 3'b010;
      nbeats = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 17) : int'(len) + 1;
      for (int i = 0; i < nbeats; i++) begin wd_buf[i] = $urandom; ws_buf[i] = 4'($urandom); end
      exp_b = (nbeats == int'(len) + 1 && size == 3'b010) ? 2'b00 : 2'b10;
      do_write(addr, len, burst, id, size, nbeats, $urandom_range(0, 3));
      n_tests++;
      if (wr_err != 0 || wr_bresp !== exp_b || wr_bid !== id) begin
        n_fail++;
        $display("FAIL rand_w%0d: err %0d bresp %b bid %0d, want 0 %b %0d", it, wr_err, wr_bresp,
                 wr_bid, exp_b, id);
      end
      if ($urandom_range(0, 1) == 1) addr = $urandom;
      len = 4'($urandom_range(0, 15)); burst = 2'($urandom_range(0, 3)); id = 4'($urandom);
      exp_rq.delete();
      do_read(addr, len, burst, id, 3'b010, 3);
      n_tests++;
      if (rd_err != 0 || rd_nb != int'(len) + 1 || rd_resp_or !== 2'b00) begin
        n_fail++;
        $display("FAIL rand_r%0d: err %0d beats %0d rresp %b, want 0 %0d 00", it, rd_err, rd_nb,
                 rd_resp_or, len + 1);
      end
      for (int i = 0; i < rd_nb; i++) begin
        logic [31:0] e;
        e = (exp_rq.size() > 0) ? exp_rq.pop_front() : 32'hX;
        n_tests++;
        if (rd_buf[i] !== e || rl_buf[i] !== (i == int'(len)) || rid_buf[i] !== id) begin
          n_fail++;
          $display("FAIL rand_r%0d_beat%0d: data %h last %b id %0d, want %h %b %0d", it, i,
                   rd_buf[i], rl_buf[i], rid_buf[i], e, i == int'(len), id);
        end
      end
      exp_rq.delete();
    end
  endtask

  initial begin
    ARESETn = 1'b0;
    bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = 3'b010; bus.AWBURST = 2'b01; bus.AWID = '0;
    bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WID = '0;
    bus.WVALID = 1'b0; bus.BREADY = 1'b0; bus.ARADDR = '0; bus.ARLEN = '0;
    bus.ARSIZE = 3'b010; bus.ARBURST = 2'b01; bus.ARID = '0; bus.ARVALID = 1'b0;
    bus.RREADY = 1'b0;
    test_reset();
    test_fill();
    test_single();
    test_burst4();
    test_strobe();
    test_slverr();
    test_fixed();
    test_concurrent();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

endmodule
